poly_arith_read_seq: RTL
========================

POLY_ARITH_READ_SEQ -- requirements
Module: poly_arith_read_seq

Interface
REQ-001 Parameter LOGN, default 0: log2 of polynomial length N.
REQ-002 Parameter PE, default 0: butterfly units; R = N/(2*PE) RAM rows per polynomial.
REQ-003 Parameter NUM_POLY, default 2: polynomials resident in RAM; AW = clog2(NUM_POLY*R).
REQ-004 Parameter DRAIN_CYCLES, default 8: cycles from last issue to done pulse.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle request to launch an operation.
REQ-008 opcode_in  in  2  0 NTT (rejected), 1 modmult, 2 modadd, 3 modsub.
REQ-009 src_a, src_b, dst  in  clog2(NUM_POLY) each  polynomial indices for operand A, operand B and result.
REQ-010 swap_in  in  1  operand bank-order select for this operation.
REQ-011 raddr  out  AW  RAM read row address.
REQ-012 ren  out  1  RAM read enable.
REQ-013 opcode  out  2  latched opcode fed to the data shuffler.
REQ-014 valid  out  1  operand-pair stream valid, to the shuffler's valid_in.
REQ-015 swap  out  1  latched swap_in, to the shuffler's swap.
REQ-016 addr  out  AW  destination row address, to the shuffler's addr.
REQ-017 busy  out  1  operation in progress (RUN or DRAIN).
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 err  out  1  one-cycle pulse on rejected start.

Function
REQ-020 FSM states SHALL be IDLE, RUN, DRAIN; reset state IDLE.
REQ-021 IDLE + start + opcode_in!=0 -> RUN next cycle; opcode_in, src_a, src_b, dst, swap_in latched on that edge.
REQ-022 IDLE + start + opcode_in==0 -> stay IDLE, err=1 one cycle after start, nothing latched.
REQ-023 start while busy SHALL be ignored, no err.
REQ-024 RUN lasts exactly 2R cycles; phase bit ph toggles each cycle starting 0; row counter k increments when ph=1.
REQ-025 In RUN: ren=1, valid=1; raddr = src_a*R+k when ph=0, src_b*R+k when ph=1.
REQ-026 In RUN: addr = dst*R+k, held constant across both phases of row k.
REQ-027 After the ph=1 cycle of k=R-1 -> DRAIN, counter cleared; k SHALL never wrap within an operation.
REQ-028 DRAIN: ren=0, valid=0, raddr/addr hold last values; after DRAIN_CYCLES cycles -> IDLE with done=1 in the first IDLE cycle.
REQ-029 busy=1 exactly in RUN and DRAIN.
REQ-030 src_a==src_b, dst equal to a source SHALL be legal; no hazard checking.
REQ-031 Index arithmetic SHALL be unsigned, AW bits; indices >= NUM_POLY are out of contract.
REQ-032 opcode and swap outputs SHALL hold latched values until the next accepted start.

Reset
REQ-033 rst low SHALL immediately force IDLE; raddr, addr, opcode, k, ph = 0; ren, valid, swap, busy, done, err = 0.
REQ-034 Reset mid-RUN or mid-DRAIN SHALL abort with no done pulse; first start after rst high is accepted normally.

Configuration
REQ-035 Macro POLY_ARITH_STALL_EN adds input stall (1 bit); when defined, stall=1 in RUN freezes ph, k, raddr, addr and forces ren=0, valid=0; in DRAIN stall is ignored.
REQ-036 Without POLY_ARITH_STALL_EN the port SHALL not exist and RUN SHALL be exactly 2R cycles.

Verification (LOGN=4, PE=2, NUM_POLY=2 -> R=4, AW=3, DRAIN_CYCLES=8)
REQ-037 start, opcode_in=2, src_a=0, src_b=1, dst=0 -> raddr 0,4,1,5,2,6,3,7; addr 0,0,1,1,2,2,3,3; valid 8 cycles; done 9 cycles after RUN ends.
REQ-038 start, opcode_in=0 -> err pulse next cycle, busy stays 0, no ren.
REQ-039 second start 3 cycles into RUN with different indices -> ignored, sequence of REQ-037 unchanged.
REQ-040 rst low at RUN cycle 5 -> all outputs 0 asynchronously; no done; new start accepted after release.
REQ-041 opcode_in=1, src_a=1, src_b=1, dst=1, swap_in=1 -> raddr 4,4,5,5,6,6,7,7; addr 4..7 pairs; swap=1, opcode=1 held.
REQ-042 (POLY_ARITH_STALL_EN) stall=1 for 3 cycles at RUN cycle 2 -> raddr sequence of REQ-037 resumes at 1, RUN spans 11 cycles.

Source files
------------

// File: rtl/poly_arith_read_seq.sv
// poly_arith_read_seq
// Read sequencer for element-wise polynomial arithmetic (modmult, modadd,
// modsub). It walks the R rows of operand A and operand B in an interleaved
// pattern (A row k, then B row k), drives the RAM read port, and hands the
// latched opcode, bank-order select and destination row to the downstream
// data shuffler. A fixed drain period lets the shuffler pipeline empty
// before done is pulsed.
//
// Parameters
//   LOGN          log2 of polynomial length N
//   PE            butterfly units; R = N/(2*PE) RAM rows per polynomial
//   NUM_POLY      polynomials resident in RAM; AW = clog2(NUM_POLY*R)
//   DRAIN_CYCLES  cycles from the last issue to the done pulse
//
// Ports
//   clk                 clock, rising edge
//   rst                 asynchronous reset, active low
//   start               one-cycle request to launch an operation
//   opcode_in [1:0]     0 NTT (rejected), 1 modmult, 2 modadd, 3 modsub
//   src_a/src_b/dst     polynomial indices for operand A, operand B, result
//   swap_in             operand bank-order select for this operation
//   stall               (POLY_ARITH_STALL_EN only) freezes issue while in RUN
//   raddr [AW-1:0]      RAM read row address
//   ren                 RAM read enable
//   opcode [1:0]        latched opcode, to the shuffler
//   valid               operand-pair stream valid, to the shuffler
//   swap                latched swap_in, to the shuffler
//   addr [AW-1:0]       destination row address, to the shuffler
//   busy                operation in progress (RUN or DRAIN)
//   done                one-cycle completion pulse
//   err                 one-cycle pulse on a rejected start
//
// Configuration
//   POLY_ARITH_STALL_EN  when defined, adds the stall input. The default
//                        build has no stall port and RUN is exactly 2R cycles.

module poly_arith_read_seq #(
  parameter int LOGN         = 0,
  parameter int PE           = 0,
  parameter int NUM_POLY     = 2,
  parameter int DRAIN_CYCLES = 8,
  // Degenerate parameter values (the PE=0 default) collapse to one row so
  // the widths below stay legal.
  localparam int N     = 1 << LOGN,
  localparam int R_RAW = (PE > 0) ? N / (2 * PE) : 1,
  localparam int R     = (R_RAW > 0) ? R_RAW : 1,
  localparam int AW    = (NUM_POLY * R > 1) ? $clog2(NUM_POLY * R) : 1,
  localparam int IW    = (NUM_POLY > 1) ? $clog2(NUM_POLY) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    opcode_in,
  input  logic [IW-1:0] src_a,
  input  logic [IW-1:0] src_b,
  input  logic [IW-1:0] dst,
  input  logic          swap_in,
`ifdef POLY_ARITH_STALL_EN
  input  logic          stall,
`endif
  output logic [AW-1:0] raddr,
  output logic          ren,
  output logic [1:0]    opcode,
  output logic          valid,
  output logic          swap,
  output logic [AW-1:0] addr,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int KW = (R > 1) ? $clog2(R) : 1;
  localparam int DC = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES : 1;
  localparam int DW = (DC > 1) ? $clog2(DC + 1) : 1;

  localparam logic [AW-1:0] R_AW   = AW'(R);
  localparam logic [KW-1:0] K_LAST = KW'(R - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] src_a_q;
  logic [IW-1:0] src_b_q;
  logic [IW-1:0] dst_q;
  logic [KW-1:0] k;        // row counter within the polynomial
  logic          ph;       // 0: operand A read, 1: operand B read
  logic [DW-1:0] dcnt;     // drain cycle counter
  logic          ren_q;
  logic          valid_q;
  logic          hold;     // freeze RUN progress this cycle

  // Row address of polynomial idx, row kk; unsigned, truncated to AW bits.
  function automatic logic [AW-1:0] row(input logic [IW-1:0] idx,
                                        input logic [KW-1:0] kk);
    return AW'(idx) * R_AW + AW'(kk);
  endfunction

`ifdef POLY_ARITH_STALL_EN
  // Stall acts within the same cycle: the issue slot is suppressed and the
  // sequencer state does not advance, so RUN stretches by one cycle per
  // stalled cycle. ren_q/valid_q are low outside RUN, so DRAIN ignores stall.
  assign hold  = (state == RUN) && stall;
  assign ren   = ren_q & ~stall;
  assign valid = valid_q & ~stall;
`else
  assign hold  = 1'b0;
  assign ren   = ren_q;
  assign valid = valid_q;
`endif

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every register samples pre-edge values; blocking here would let later
  // statements see half-updated state and break the row/phase sequencing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
      k       <= '0;
      ph      <= 1'b0;
      dcnt    <= '0;
      raddr   <= '0;
      addr    <= '0;
      opcode  <= 2'd0;
      swap    <= 1'b0;
      ren_q   <= 1'b0;
      valid_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      // Pulses default low; only the branches below raise them for one cycle.
      done <= 1'b0;
      err  <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            if (opcode_in != 2'd0) begin
              // Outputs for the first RUN cycle are loaded on the accepting
              // edge so ren/raddr are valid in the very first RUN cycle.
              state   <= RUN;
              opcode  <= opcode_in;
              swap    <= swap_in;
              src_a_q <= src_a;
              src_b_q <= src_b;
              dst_q   <= dst;
              ph      <= 1'b0;
              k       <= '0;
              raddr   <= row(src_a, '0);
              addr    <= row(dst, '0);
              ren_q   <= 1'b1;
              valid_q <= 1'b1;
              busy    <= 1'b1;
            end else begin
              // NTT is not handled by this sequencer: reject, latch nothing.
              err <= 1'b1;
            end
          end
        end

        RUN: begin
          if (!hold) begin
            if (!ph) begin
              // A row k was just issued; B row k follows, addr stays on row k.
              ph    <= 1'b1;
              raddr <= row(src_b_q, k);
            end else if (k == K_LAST) begin
              // Last pair issued: clear the counter instead of wrapping it.
              state   <= DRAIN;
              ph      <= 1'b0;
              k       <= '0;
              dcnt    <= '0;
              ren_q   <= 1'b0;
              valid_q <= 1'b0;
            end else begin
              ph    <= 1'b0;
              k     <= k + 1'b1;
              raddr <= row(src_a_q, k + 1'b1);
              addr  <= row(dst_q, k + 1'b1);
            end
          end
        end

        DRAIN: begin
          // raddr/addr are not touched here, so they hold their last values.
          if (dcnt == D_LAST) begin
            state <= IDLE;
            dcnt  <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
